// File: rtl/hazard_if.sv
// hazard_if: pipeline-to-hazard-controller signal bundle
interface hazard_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              ex_regwrite;
  logic              ex_memtoreg;
  logic              br_taken;
  logic              id_halt;
  logic              imem_busy;
  logic              dmem_busy;
  logic              pc_we;
  logic              ifid_we;
  logic              exmem_we;
  logic              memwb_we;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;
  modport master (
    output id_rs, id_rt, ex_rd, id_rs_used, id_rt_used, ex_regwrite, ex_memtoreg,
           br_taken, id_halt, imem_busy, dmem_busy,
    input  pc_we, ifid_we, exmem_we, memwb_we, ifid_flush, idex_bubble, halted, stall_cnt
  );
  modport slave (
    input  id_rs, id_rt, ex_rd, id_rs_used, id_rt_used, ex_regwrite, ex_memtoreg,
           br_taken, id_halt, imem_busy, dmem_busy,
    output pc_we, ifid_we, exmem_we, memwb_we, ifid_flush, idex_bubble, halted, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, memory freeze, branch squash and halt drain for the 5-stage pipe
module hazard_ctrl #(
  parameter int REG_AW     = 4,
  parameter int HALT_DRAIN = 3,
  parameter int CNT_W      = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);
  localparam int DW = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t            state, state_n;
  logic [DW-1:0]     cnt, cnt_n;
  logic [CNT_W-1:0]  stall_q;
  logic              lu;
  assign lu = hz.ex_regwrite & hz.ex_memtoreg &
              ((hz.id_rs_used & (hz.id_rs == hz.ex_rd)) | (hz.id_rt_used & (hz.id_rt == hz.ex_rd)));
  assign hz.halted    = (state == HALTED);
  assign hz.stall_cnt = stall_q;
  // state, drain counter and saturating lost-fetch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      cnt     <= '0;
      stall_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      stall_q <= (state == RUN && !hz.pc_we && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    end
  end
  // halt enters DRAIN only when no freeze, branch or load-use outranks it; drain pauses on dmem wait
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == RUN && !hz.dmem_busy && !hz.br_taken && !lu && hz.id_halt) begin
      state_n = DRAIN;
      cnt_n   = DW'(HALT_DRAIN - 1);
    end else if (state == DRAIN && !hz.dmem_busy) begin
      state_n = (cnt == '0) ? HALTED : DRAIN;
      cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
    end
  end
  // stage controls: priority dmem_busy > br_taken > lu > id_halt > imem_busy while running
  always_comb begin
    hz.pc_we       = 1'b0;
    hz.ifid_we     = 1'b0;
    hz.exmem_we    = 1'b0;
    hz.memwb_we    = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.idex_bubble = 1'b0;
    if (rst_n && state == RUN && !hz.dmem_busy) begin
      hz.pc_we       = hz.br_taken | !(lu | hz.id_halt | hz.imem_busy);
      hz.ifid_we     = hz.br_taken | !lu;
      hz.exmem_we    = 1'b1;
      hz.memwb_we    = 1'b1;
      hz.ifid_flush  = hz.br_taken | (!lu & (hz.id_halt | hz.imem_busy));
      hz.idex_bubble = hz.br_taken | lu;
    end else if (rst_n && state == DRAIN) begin
      hz.ifid_we     = 1'b1;
      hz.exmem_we    = !hz.dmem_busy;
      hz.memwb_we    = !hz.dmem_busy;
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a rule-level model
module tb_hazard_ctrl;
  localparam int REG_AW = 4, HALT_DRAIN = 3, CNT_W = 16;
  localparam longint SMAX = (64'd1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0, mismatched = 0;
  int mode = 0, left = 0;
  longint stalls = 0;
  hazard_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz();
  hazard_ctrl #(.REG_AW(REG_AW), .HALT_DRAIN(HALT_DRAIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [5:0] ctl();
    return {hz.pc_we, hz.ifid_we, hz.exmem_we, hz.memwb_we, hz.ifid_flush, hz.idex_bubble};
  endfunction
  function automatic bit m_lu();
    return hz.ex_regwrite && hz.ex_memtoreg &&
           ((hz.id_rs_used && hz.id_rs == hz.ex_rd) || (hz.id_rt_used && hz.id_rt == hz.ex_rd));
  endfunction
  // expected {pc, ifid, exmem, memwb, flush, bubble} from the row table
  function automatic logic [5:0] m_out();
    bit pc = 1, ifid = 1, exm = 1, mwb = 1, fl = 0, bub = 0;
    if (mode == 2) begin
      pc = 0; ifid = 0; exm = 0; mwb = 0;
    end else if (mode == 1) begin
      pc = 0; fl = 1; bub = 1; exm = !hz.dmem_busy; mwb = !hz.dmem_busy;
    end else if (hz.dmem_busy) begin
      pc = 0; ifid = 0; exm = 0; mwb = 0;
    end else if (hz.br_taken) begin
      fl = 1; bub = 1;
    end else if (m_lu()) begin
      pc = 0; ifid = 0; bub = 1;
    end else if (hz.id_halt || hz.imem_busy) begin
      pc = 0; fl = 1;
    end
    return {pc, ifid, exm, mwb, fl, bub};
  endfunction
  task automatic idle();
    hz.id_rs = '0; hz.id_rt = '0; hz.ex_rd = '0;
    hz.id_rs_used = 0; hz.id_rt_used = 0; hz.ex_regwrite = 0; hz.ex_memtoreg = 0;
    hz.br_taken = 0; hz.id_halt = 0; hz.imem_busy = 0; hz.dmem_busy = 0;
  endtask
  task automatic step(input string tag, input bit check);
    logic [5:0] e;
    @(negedge clk);
    e = m_out();
    if (check) begin
      chk({tag, ".ctl"}, 64'(ctl()), 64'(e));
      chk({tag, ".halted"}, 64'(hz.halted), 64'(mode == 2));
      chk({tag, ".stall"}, 64'(hz.stall_cnt), 64'(stalls));
    end
    @(posedge clk);
    if (mode == 0) begin
      if (!e[5] && stalls < SMAX) stalls++;
      if (!hz.dmem_busy && !hz.br_taken && !m_lu() && hz.id_halt) begin
        mode = 1; left = HALT_DRAIN - 1;
      end
    end else if (mode == 1 && !hz.dmem_busy) begin
      if (left == 0) mode = 2; else left--;
    end
    #1;
  endtask
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, ".rst_ctl"}, 64'(ctl()), 64'd0);
    chk({tag, ".rst_halted"}, 64'(hz.halted), 64'd0);
    chk({tag, ".rst_stall"}, 64'(hz.stall_cnt), 64'd0);
    mode = 0; left = 0; stalls = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    int n;
    idle();
    #2;
    apply_reset("init");
    step("idle", 1);
    hz.ex_regwrite = 1; hz.ex_memtoreg = 1; hz.ex_rd = 4'd3; hz.id_rs = 4'd3; hz.id_rs_used = 1;
    step("lu", 1);
    hz.ex_memtoreg = 0;
    step("lu_after", 1);
    chk("lu_stall_one", 64'(hz.stall_cnt), 64'd1);
    hz.ex_memtoreg = 1; hz.id_rs_used = 0;
    step("lu_unused", 1);
    hz.id_rs_used = 1; hz.ex_memtoreg = 0;
    step("alu_match", 1);
    hz.ex_memtoreg = 1; hz.br_taken = 1; hz.imem_busy = 1;
    step("br_lu_imem", 1);
    idle();
    hz.br_taken = 1; hz.dmem_busy = 1;
    repeat (3) step("freeze", 1);
    hz.dmem_busy = 0;
    step("freeze_end", 1);
    hz.id_halt = 1;
    step("br_halt", 1);
    idle();
    hz.id_halt = 1;
    step("halt", 1);
    hz.id_halt = 0;
    n = 1;
    for (int i = 0; i < 10 && !hz.halted; i++) begin
      hz.dmem_busy = (n == 2);
      step("drain", 1);
      n++;
    end
    hz.dmem_busy = 0;
    chk("halt_latency", 64'(n), 64'd5);
    hz.br_taken = 1;
    step("halted_br", 1);
    idle();
    apply_reset("from_halted");
    step("after_rst", 1);
    hz.id_halt = 1;
    step("halt2", 1);
    hz.id_halt = 0;
    step("drain2", 1);
    apply_reset("mid_drain");
    step("after_rst2", 1);
    for (int i = 0; i < 400; i++) begin
      hz.id_rs = REG_AW'($urandom_range(0, 3));
      hz.id_rt = REG_AW'($urandom_range(0, 3));
      hz.ex_rd = REG_AW'($urandom_range(0, 3));
      hz.id_rs_used = 1'($urandom);
      hz.id_rt_used = 1'($urandom);
      hz.ex_regwrite = 1'($urandom);
      hz.ex_memtoreg = 1'($urandom);
      hz.br_taken = ($urandom_range(0, 7) == 0);
      hz.dmem_busy = ($urandom_range(0, 5) == 0);
      hz.imem_busy = ($urandom_range(0, 3) == 0);
      hz.id_halt = ($urandom_range(0, 15) == 0);
      if (mode == 2 && $urandom_range(0, 3) == 0) apply_reset("rand");
      step("rand", 1);
    end
    idle();
    apply_reset("sat");
    hz.imem_busy = 1;
    repeat ((1 << CNT_W) + 4) step("sat", 0);
    step("sat_hold", 1);
    chk("sat_ones", 64'(hz.stall_cnt), 64'(SMAX));
    step("sat_hold2", 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage CPU. It produces per-stage register write enables, flush and bubble controls, and a halt indication. Inputs are ID/EX operand addresses, data- and instruction-memory wait signals, branch resolution and a decoded halt. It sits beside the forwarding unit: forwarding covers ALU-to-ALU dependencies, and this block inserts the load-use stall, freezes the pipe on memory wait, squashes wrong-path instructions and drains the pipe on halt.

## Interface
- REG_AW, 4, register address width
- HALT_DRAIN, 3, cycles after the halt leaves ID before the pipe is considered empty (must be ≥1)
- CNT_W, 16, stall counter width

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_rs, id_rt  in  REG_AW  source registers of the instruction in ID
- id_rs_used, id_rt_used  in  1  source actually read
- ex_rd  in  REG_AW  destination of the instruction in EX
- ex_regwrite  in  1  EX instruction writes a register
- ex_memtoreg  in  1  EX instruction is a load
- br_taken  in  1  branch or jump in EX redirects the PC
- id_halt  in  1  halt decoded in ID
- imem_busy  in  1  fetch not ready this cycle
- dmem_busy  in  1  MEM-stage access not ready this cycle
- pc_we, ifid_we, exmem_we, memwb_we  out  1  register/stage write enables
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  load NOP into ID/EX
- halted  out  1  pipe drained after halt
- stall_cnt  out  CNT_W  lost-fetch cycle counter

## Operation
- States: RUN, DRAIN, HALTED. Reset → RUN, drain counter 0, stall_cnt 0.
- Load-use hazard: lu = ex_regwrite & ex_memtoreg & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
- RUN outputs, first matching row wins. Defaults are all we=1, flush=0, bubble=0.
  - dmem_busy: pc_we=ifid_we=exmem_we=memwb_we=0, no flush, no bubble. This freezes the whole pipe, and any br_taken or lu is re-evaluated next cycle.
  - br_taken: pc_we=1, ifid_flush=1, idex_bubble=1. This overrides lu, id_halt and imem_busy.
  - lu: pc_we=0, ifid_we=0, idex_bubble=1. The load advances, so lu clears on its own after one cycle.
  - id_halt: pc_we=0, ifid_flush=1. The halt advances into EX. Next state is DRAIN with counter=HALT_DRAIN−1.
  - imem_busy: pc_we=0, ifid_flush=1, and downstream stages advance.
- DRAIN: pc_we=0, ifid_flush=1, idex_bubble=1, and exmem/memwb follow dmem_busy (0 when busy, else 1).
  - br_taken, lu, id_halt and imem_busy are ignored.
  - The counter decrements only on cycles with dmem_busy=0.
  - With counter==0 and dmem_busy=0, next state is HALTED.
- HALTED: all we=0, flush=0, bubble=0, halted=1. Only rst_n exits.
- stall_cnt increments when state==RUN and pc_we==0, and saturates at all-ones.

## Timing
- All enables, flush and bubble are combinational from inputs and state in the same cycle. There are no registered outputs except halted and stall_cnt.
- Reset asserted (rst_n=0), asynchronously:
  - All we=0, flush=0, bubble=0, halted=0, stall_cnt=0.
  - State returns to RUN mid-drain or from HALTED.
- Values after reset release with idle inputs: pc_we=ifid_we=exmem_we=memwb_we=1, halted=0.
- Load-use costs exactly one bubble. Branch costs two squashed slots. A freeze holds for exactly as many cycles as dmem_busy is high.
- halted rises HALTED_DRAIN+1 clocks after the id_halt cycle, plus one clock per dmem_busy cycle during DRAIN.
- Simultaneous events:
  - br_taken with id_halt: the halt is squashed and the state stays RUN.
  - lu with imem_busy: lu row applies (pc_we=0, ifid_we=0, idex_bubble=1).

## Test plan
- Load r3 in EX, ID reads rs=3 with rs_used=1 → one cycle with pc_we=0, ifid_we=0, idex_bubble=1. The next cycle (ex_memtoreg=0) returns to all enables 1. stall_cnt=1.
- Same load-use with id_rs_used=0 → no stall. ex_rd match with ex_memtoreg=0 → no stall.
- br_taken with lu and imem_busy also high → pc_we=1, ifid_flush=1, idex_bubble=1, ifid_we=1.
- dmem_busy high for 3 cycles with br_taken held → 3 cycles of all we=0, no flush. Flush occurs on the 4th cycle.
- id_halt with HALT_DRAIN=3 and dmem_busy pulsed 1 cycle inside DRAIN → halted=1 after 5 clocks. In HALTED, all we=0 and br_taken is ignored. rst_n low → halted=0 immediately and all we=0. After release → RUN.
- Hold imem_busy for 2^CNT_W+5 cycles → stall_cnt saturates at all-ones and does not wrap.
